// File: rtl/seg_src_arbiter.sv
// seg_src_arbiter
//   Chooses which of two requesters (A, B) owns the two-digit 7-segment
//   display. An accepted value is held on din0/din1 for DWELL clock cycles
//   before a new request can be accepted. When both requesters are valid
//   at once they are served in round-robin order.
//
// Ports
//   clk              system clock, rising-edge
//   rst              asynchronous reset, active low
//   a_valid/a_data   requester A offer; a_data[3:0] digit 0, [7:4] digit 1
//   a_ready          A accepted this cycle (combinational, IDLE only)
//   b_valid/b_data   requester B offer, same packing as A
//   b_ready          B accepted this cycle (combinational, IDLE only)
//   din0/din1        displayed digits
//   owner            source of displayed value: 00 none, 01 A, 10 B
//   busy             high while the dwell hold is running
module seg_src_arbiter #(
  parameter int unsigned DWELL = 16000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       a_valid,
  input  logic [7:0] a_data,
  output logic       a_ready,
  input  logic       b_valid,
  input  logic [7:0] b_data,
  output logic       b_ready,
  output logic [3:0] din0,
  output logic [3:0] din1,
  output logic [1:0] owner,
  output logic       busy
);

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_t;

  localparam logic        LW_A     = 1'b0;
  localparam logic        LW_B     = 1'b1;
  localparam logic [23:0] DWELL_M1 = 24'(DWELL - 1);

  state_t      state_q, state_d;
  logic [23:0] cnt_q, cnt_d;
  logic [3:0]  din0_q, din0_d;
  logic [3:0]  din1_q, din1_d;
  logic [1:0]  owner_q, owner_d;
  logic        busy_q, busy_d;
  logic        last_q, last_d;

  logic a_grant;
  logic b_grant;

  // Grants exist only in IDLE and are forced low while reset is held, so
  // readies read 0 during reset regardless of the clock. On a tie the
  // requester that did not win last time is chosen.
  always_comb begin
    a_grant = 1'b0;
    b_grant = 1'b0;
    if (rst && (state_q == IDLE)) begin
      if (a_valid && b_valid) begin
        if (last_q == LW_B) begin
          a_grant = 1'b1;
        end else begin
          b_grant = 1'b1;
        end
      end else begin
        a_grant = a_valid;
        b_grant = b_valid;
      end
    end
  end

  assign a_ready = a_grant;
  assign b_ready = b_grant;

  // Next-state logic. A grant implies the matching valid, so a grant is
  // a transfer. The counter loads DWELL-1 and HOLD exits on the edge where
  // it reads zero, which gives exactly DWELL HOLD cycles.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    din0_d  = din0_q;
    din1_d  = din1_q;
    owner_d = owner_q;
    busy_d  = busy_q;
    last_d  = last_q;
    case (state_q)
      IDLE: begin
        if (a_grant) begin
          din0_d  = a_data[3:0];
          din1_d  = a_data[7:4];
          owner_d = 2'b01;
          last_d  = LW_A;
          state_d = HOLD;
          cnt_d   = DWELL_M1;
          busy_d  = 1'b1;
        end else if (b_grant) begin
          din0_d  = b_data[3:0];
          din1_d  = b_data[7:4];
          owner_d = 2'b10;
          last_d  = LW_B;
          state_d = HOLD;
          cnt_d   = DWELL_M1;
          busy_d  = 1'b1;
        end
      end
      HOLD: begin
        if (cnt_q == 24'd0) begin
          state_d = IDLE;
          busy_d  = 1'b0;
        end else begin
          cnt_d = cnt_q - 24'd1;
        end
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= 24'd0;
      din0_q  <= 4'd0;
      din1_q  <= 4'd0;
      owner_q <= 2'b00;
      busy_q  <= 1'b0;
      last_q  <= LW_B;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      din0_q  <= din0_d;
      din1_q  <= din1_d;
      owner_q <= owner_d;
      busy_q  <= busy_d;
      last_q  <= last_d;
    end
  end

  assign din0  = din0_q;
  assign din1  = din1_q;
  assign owner = owner_q;
  assign busy  = busy_q;

endmodule

// File: tb/tb_seg_src_arbiter.sv
// tb_seg_src_arbiter
//   Two arbiter instances: u0 with DWELL=4 and u1 with DWELL=1. A
//   time-based model tracks, per instance, the edge index at which the
//   current hold window ends, the last winner and the displayed value.
//   A negedge process compares every output of both instances against it,
//   while the directed sequence adds literal expectations.
module tb_seg_src_arbiter;

  localparam int DW0 = 4;
  localparam int DW1 = 1;

  logic       clk = 1'b0;
  logic       rst;
  logic       a_valid [2];
  logic [7:0] a_data  [2];
  logic       b_valid [2];
  logic [7:0] b_data  [2];
  logic       a_ready [2];
  logic       b_ready [2];
  logic [3:0] din0    [2];
  logic [3:0] din1    [2];
  logic [1:0] owner   [2];
  logic       busy    [2];

  int n_cmp = 0;
  int n_bad = 0;
  logic chk_en = 1'b0;

  always #5 clk = ~clk;

  seg_src_arbiter #(.DWELL(DW0)) u0 (
    .clk(clk), .rst(rst),
    .a_valid(a_valid[0]), .a_data(a_data[0]), .a_ready(a_ready[0]),
    .b_valid(b_valid[0]), .b_data(b_data[0]), .b_ready(b_ready[0]),
    .din0(din0[0]), .din1(din1[0]), .owner(owner[0]), .busy(busy[0])
  );

  seg_src_arbiter #(.DWELL(DW1)) u1 (
    .clk(clk), .rst(rst),
    .a_valid(a_valid[1]), .a_data(a_data[1]), .a_ready(a_ready[1]),
    .b_valid(b_valid[1]), .b_data(b_data[1]), .b_ready(b_ready[1]),
    .din0(din0[1]), .din1(din1[1]), .owner(owner[1]), .busy(busy[1])
  );

  // Model state: m_k counts rising edges since reset; the instance is busy
  // while m_k < m_end, where m_end = transfer edge + DWELL.
  int         m_k    [2] = '{0, 0};
  int         m_end  [2] = '{0, 0};
  logic [3:0] m_d0   [2] = '{4'd0, 4'd0};
  logic [3:0] m_d1   [2] = '{4'd0, 4'd0};
  logic [1:0] m_own  [2] = '{2'b00, 2'b00};
  logic       m_lastb[2] = '{1'b1, 1'b1};
  logic [1:0] g_m;
  logic [1:0] g_c;

  function automatic int dwell_of(input int d);
    return (d == 0) ? DW0 : DW1;
  endfunction

  // Expected {b_ready, a_ready} from the model and current inputs.
  function automatic logic [1:0] exp_rdy(input int d);
    if (rst !== 1'b1) return 2'b00;
    if (m_k[d] < m_end[d]) return 2'b00;
    if (a_valid[d] && b_valid[d]) return m_lastb[d] ? 2'b01 : 2'b10;
    return {b_valid[d], a_valid[d]};
  endfunction

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int d = 0; d < 2; d++) begin
        m_k[d]     = 0;
        m_end[d]   = 0;
        m_d0[d]    = 4'd0;
        m_d1[d]    = 4'd0;
        m_own[d]   = 2'b00;
        m_lastb[d] = 1'b1;
      end
    end else begin
      for (int d = 0; d < 2; d++) begin
        g_m = exp_rdy(d);
        m_k[d] = m_k[d] + 1;
        if (g_m[0]) begin
          m_d0[d]    = a_data[d][3:0];
          m_d1[d]    = a_data[d][7:4];
          m_own[d]   = 2'b01;
          m_lastb[d] = 1'b0;
          m_end[d]   = m_k[d] + dwell_of(d);
        end else if (g_m[1]) begin
          m_d0[d]    = b_data[d][3:0];
          m_d1[d]    = b_data[d][7:4];
          m_own[d]   = 2'b10;
          m_lastb[d] = 1'b1;
          m_end[d]   = m_k[d] + dwell_of(d);
        end
      end
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] act,
                             input logic [31:0] expv);
    n_cmp = n_cmp + 1;
    if (act !== expv) begin
      n_bad = n_bad + 1;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      for (int d = 0; d < 2; d++) begin
        g_c = exp_rdy(d);
        checkOutput($sformatf("u%0d a_ready", d), 32'(a_ready[d]), 32'(g_c[0]));
        checkOutput($sformatf("u%0d b_ready", d), 32'(b_ready[d]), 32'(g_c[1]));
        checkOutput($sformatf("u%0d din0", d), 32'(din0[d]), 32'(m_d0[d]));
        checkOutput($sformatf("u%0d din1", d), 32'(din1[d]), 32'(m_d1[d]));
        checkOutput($sformatf("u%0d owner", d), 32'(owner[d]), 32'(m_own[d]));
        checkOutput($sformatf("u%0d busy", d), 32'(busy[d]),
                    32'(m_k[d] < m_end[d]));
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input int d, input logic av, input logic [7:0] ad,
                               input logic bv, input logic [7:0] bd);
    a_valid[d] = av;
    a_data[d]  = ad;
    b_valid[d] = bv;
    b_data[d]  = bd;
  endtask

  initial begin
    int   busy_cnt;
    logic b_seen;

    rst = 1'b0;
    applyStimulus(0, 1'b1, 8'h21, 1'b0, 8'h00);
    applyStimulus(1, 1'b0, 8'h00, 1'b0, 8'h00);
    #1 chk_en = 1'b1;

    // Reset holds readies low even with a valid present.
    #11;
    checkOutput("rst a_ready", 32'(a_ready[0]), 32'd0);
    checkOutput("rst owner", 32'(owner[0]), 32'd0);
    checkOutput("rst busy", 32'(busy[0]), 32'd0);

    // First transfer right after release, then 4 busy cycles.
    tick(1);
    rst = 1'b1;
    #2;
    checkOutput("first a_ready", 32'(a_ready[0]), 32'd1);
    tick(1);
    applyStimulus(0, 1'b0, 8'h21, 1'b0, 8'h00);
    checkOutput("first din0", 32'(din0[0]), 32'd1);
    checkOutput("first din1", 32'(din1[0]), 32'd2);
    checkOutput("first owner", 32'(owner[0]), 32'd1);
    checkOutput("first busy", 32'(busy[0]), 32'd1);
    busy_cnt = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (busy[0] === 1'b1) busy_cnt = busy_cnt + 1;
    end
    checkOutput("busy cycles", 32'(busy_cnt), 32'd4);

    // Long idle: display must persist.
    tick(100);
    checkOutput("idle din0", 32'(din0[0]), 32'd1);
    checkOutput("idle din1", 32'(din1[0]), 32'd2);
    checkOutput("idle owner", 32'(owner[0]), 32'd1);
    checkOutput("idle busy", 32'(busy[0]), 32'd0);

    // B pulses only during A's hold and is never accepted.
    applyStimulus(0, 1'b1, 8'h21, 1'b0, 8'h00);
    tick(1);
    applyStimulus(0, 1'b0, 8'h21, 1'b1, 8'h99);
    b_seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (b_ready[0] === 1'b1) b_seen = 1'b1;
      @(posedge clk);
      #1;
      if (i == 1) b_valid[0] = 1'b0;
    end
    checkOutput("pulse b_ready seen", 32'(b_seen), 32'd0);
    checkOutput("pulse owner", 32'(owner[0]), 32'd1);
    checkOutput("pulse data", 32'({din1[0], din0[0]}), 32'h21);

    // Both valid out of reset: strict alternation A, B, A.
    tick(1);
    rst = 1'b0;
    applyStimulus(0, 1'b1, 8'h21, 1'b1, 8'h43);
    tick(2);
    rst = 1'b1;
    tick(1);
    checkOutput("rr1 owner", 32'(owner[0]), 32'd1);
    checkOutput("rr1 data", 32'({din1[0], din0[0]}), 32'h21);
    tick(5);
    checkOutput("rr2 owner", 32'(owner[0]), 32'd2);
    checkOutput("rr2 din0", 32'(din0[0]), 32'd3);
    checkOutput("rr2 din1", 32'(din1[0]), 32'd4);
    tick(5);
    checkOutput("rr3 owner", 32'(owner[0]), 32'd1);
    checkOutput("rr3 data", 32'({din1[0], din0[0]}), 32'h21);

    // Asynchronous reset two cycles into hold, between clock edges.
    tick(1);
    #2;
    rst = 1'b0;
    #1;
    checkOutput("async owner", 32'(owner[0]), 32'd0);
    checkOutput("async din", 32'({din1[0], din0[0]}), 32'h00);
    checkOutput("async busy", 32'(busy[0]), 32'd0);
    checkOutput("async readies", 32'({b_ready[0], a_ready[0]}), 32'd0);
    tick(2);
    rst = 1'b1;
    #2;
    checkOutput("post-rst a_ready", 32'(a_ready[0]), 32'd1);
    checkOutput("post-rst b_ready", 32'(b_ready[0]), 32'd0);
    tick(1);
    checkOutput("post-rst owner", 32'(owner[0]), 32'd1);
    applyStimulus(0, 1'b0, 8'h00, 1'b0, 8'h00);
    tick(6);

    // DWELL=1 instance: A always valid, a new value after each transfer.
    applyStimulus(1, 1'b1, 8'h10, 1'b0, 8'h00);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      checkOutput($sformatf("dw1 a_ready[%0d]", i), 32'(a_ready[1]),
                  32'((i % 2) == 0));
      @(posedge clk);
      #1;
      if ((i % 2) == 0) begin
        checkOutput($sformatf("dw1 shown[%0d]", i), 32'({din1[1], din0[1]}),
                    32'(8'h10 + 8'(i / 2)));
        a_data[1] = 8'h10 + 8'(i / 2) + 8'd1;
      end
    end
    applyStimulus(1, 1'b0, 8'h00, 1'b0, 8'h00);
    tick(3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
